// File: rtl/multicycle_alu_if.sv
// Bundle of the ALU command and result signals shared by the requester and the ALU.
interface multicycle_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] resultHi;
  logic [3:0]       ccr;
  logic [3:0]       ccrShadow;

  modport master (
    output start, opcode, opA, opB, flush,
    input  busy, done, result, resultHi, ccr, ccrShadow
  );

  modport slave (
    input  start, opcode, opA, opB, flush,
    output busy, done, result, resultHi, ccr, ccrShadow
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops, WIDTH-cycle shift-add multiply,
// condition-code register {NF,OF,CF,ZF} with a one-deep shadow copy.
module multicycle_alu #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input logic               clk,
  input logic               rst_n,
  multicycle_alu_if.slave   bus
);

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_ADD     = 4'd1;
  localparam logic [3:0] OP_SUB     = 4'd2;
  localparam logic [3:0] OP_AND     = 4'd3;
  localparam logic [3:0] OP_OR      = 4'd4;
  localparam logic [3:0] OP_NOT     = 4'd5;
  localparam logic [3:0] OP_INC     = 4'd6;
  localparam logic [3:0] OP_DEC     = 4'd7;
  localparam logic [3:0] OP_SHL     = 4'd8;
  localparam logic [3:0] OP_SHR     = 4'd9;
  localparam logic [3:0] OP_MOV     = 4'd10;
  localparam logic [3:0] OP_MUL     = 4'd11;
  localparam logic [3:0] OP_SETC    = 4'd12;
  localparam logic [3:0] OP_CLRC    = 4'd13;
  localparam logic [3:0] OP_SAVE    = 4'd14;
  localparam logic [3:0] OP_RESTORE = 4'd15;

  localparam logic [WIDTH-1:0] L_WIDTH    = WIDTH'(WIDTH);
  localparam logic [CNTW-1:0]  L_LASTITER = CNTW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [CNTW-1:0]    r_count;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_resultHi;
  logic [3:0]         r_ccr;
  logic [3:0]         r_ccrShadow;

  logic               w_accept;
  logic               w_mulStep;
  logic               w_mulLast;
  logic [2*WIDTH-1:0] w_accNext;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_inc;
  logic [WIDTH:0]     w_dec;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic               w_shTooFar;
  logic               w_ofAdd;
  logic               w_ofSub;
  logic [WIDTH-1:0]   w_aluRes;
  logic [3:0]         w_aluCcr;
  logic [3:0]         w_aluShadow;

  // A start is only taken in IDLE, and a simultaneous flush cancels it.
  assign w_accept  = (r_state == IDLE) && bus.start && !bus.flush;
  assign w_mulStep = (r_state == MUL) && !bus.flush;
  assign w_mulLast = w_mulStep && (r_count == L_LASTITER);
  assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Widened arithmetic so the carry/borrow lands in the top bit.
  assign w_sum  = {1'b0, bus.opA} + {1'b0, bus.opB};
  assign w_diff = {1'b0, bus.opB} - {1'b0, bus.opA};
  assign w_inc  = {1'b0, bus.opA} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec  = {1'b0, bus.opA} - {{WIDTH{1'b0}}, 1'b1};

  // Extra bit on the exit side of each shifter captures the last bit shifted out.
  assign w_shl      = {1'b0, bus.opA} << bus.opB;
  assign w_shr      = {bus.opA, 1'b0} >> bus.opB;
  assign w_shTooFar = bus.opB > L_WIDTH;

  assign w_ofAdd = (bus.opA[WIDTH-1] == bus.opB[WIDTH-1]) && (w_sum[WIDTH-1] != bus.opA[WIDTH-1]);
  assign w_ofSub = (bus.opB[WIDTH-1] != bus.opA[WIDTH-1]) && (w_diff[WIDTH-1] != bus.opB[WIDTH-1]);

  // Single-cycle result and flag computation for every opcode except MUL.
  always_comb begin
    w_aluRes    = '0;
    w_aluCcr    = r_ccr;
    w_aluShadow = r_ccrShadow;
    case (bus.opcode)
      OP_ADD: begin
        w_aluRes = w_sum[WIDTH-1:0];
        w_aluCcr = {w_sum[WIDTH-1], w_ofAdd, w_sum[WIDTH], w_sum[WIDTH-1:0] == '0};
      end
      OP_SUB: begin
        w_aluRes = w_diff[WIDTH-1:0];
        w_aluCcr = {w_diff[WIDTH-1], w_ofSub, w_diff[WIDTH], w_diff[WIDTH-1:0] == '0};
      end
      OP_AND: begin
        w_aluRes    = bus.opA & bus.opB;
        w_aluCcr[3] = w_aluRes[WIDTH-1];
        w_aluCcr[0] = (w_aluRes == '0);
      end
      OP_OR: begin
        w_aluRes    = bus.opA | bus.opB;
        w_aluCcr[3] = w_aluRes[WIDTH-1];
        w_aluCcr[0] = (w_aluRes == '0);
      end
      OP_NOT: begin
        w_aluRes    = ~bus.opA;
        w_aluCcr[3] = w_aluRes[WIDTH-1];
        w_aluCcr[0] = (w_aluRes == '0);
      end
      OP_INC: begin
        w_aluRes    = w_inc[WIDTH-1:0];
        w_aluCcr[3] = w_inc[WIDTH-1];
        w_aluCcr[1] = w_inc[WIDTH];
        w_aluCcr[0] = (w_inc[WIDTH-1:0] == '0);
      end
      OP_DEC: begin
        w_aluRes    = w_dec[WIDTH-1:0];
        w_aluCcr[3] = w_dec[WIDTH-1];
        w_aluCcr[1] = w_dec[WIDTH];
        w_aluCcr[0] = (w_dec[WIDTH-1:0] == '0);
      end
      OP_SHL: begin
        if (bus.opB == '0) begin
          w_aluRes    = bus.opA;
          w_aluCcr[1] = 1'b0;
        end else if (w_shTooFar) begin
          w_aluRes    = '0;
          w_aluCcr[1] = 1'b0;
        end else begin
          w_aluRes    = w_shl[WIDTH-1:0];
          w_aluCcr[1] = w_shl[WIDTH];
        end
        w_aluCcr[3] = w_aluRes[WIDTH-1];
        w_aluCcr[0] = (w_aluRes == '0);
      end
      OP_SHR: begin
        if (bus.opB == '0) begin
          w_aluRes    = bus.opA;
          w_aluCcr[1] = 1'b0;
        end else if (w_shTooFar) begin
          w_aluRes    = '0;
          w_aluCcr[1] = 1'b0;
        end else begin
          w_aluRes    = w_shr[WIDTH:1];
          w_aluCcr[1] = w_shr[0];
        end
        w_aluCcr[3] = w_aluRes[WIDTH-1];
        w_aluCcr[0] = (w_aluRes == '0);
      end
      OP_MOV:     w_aluRes    = bus.opB;
      OP_SETC:    w_aluCcr[1] = 1'b1;
      OP_CLRC:    w_aluCcr[1] = 1'b0;
      OP_SAVE:    w_aluShadow = r_ccr;
      OP_RESTORE: w_aluCcr    = r_ccrShadow;
      default:    w_aluRes    = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // FSM next-state: flush aborts MUL/DONE, MUL runs until its last iteration.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_stateNext = (bus.opcode == OP_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (bus.flush)     w_stateNext = IDLE;
        else if (w_mulLast) w_stateNext = DONE;
      end
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath: latch operands on a MUL start, iterate while in MUL, and commit
  // result/flags only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_resultHi  <= '0;
      r_ccr       <= '0;
      r_ccrShadow <= '0;
    end else if (w_accept) begin
      if (bus.opcode == OP_MUL) begin
        r_count  <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, bus.opA};
        r_mplier <= bus.opB;
        r_acc    <= '0;
      end else begin
        r_result    <= w_aluRes;
        r_resultHi  <= '0;
        r_ccr       <= w_aluCcr;
        r_ccrShadow <= w_aluShadow;
      end
    end else if (w_mulStep) begin
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
      if (w_mulLast) begin
        r_count    <= '0;
        r_result   <= w_accNext[WIDTH-1:0];
        r_resultHi <= w_accNext[2*WIDTH-1:WIDTH];
        r_ccr      <= {w_accNext[WIDTH-1], r_ccr[2],
                       w_accNext[2*WIDTH-1:WIDTH] != '0, w_accNext == '0};
      end
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.resultHi  = r_resultHi;
  assign bus.ccr       = r_ccr;
  assign bus.ccrShadow = r_ccrShadow;

endmodule
